// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle instruction sequencer for a small
// load/store datapath. It fetches 16-bit instructions from a synchronous
// ROM, decodes the opcode and steps the datapath controls one state at a
// time. Datapath controls are decoded from the state register and IR. The
// only exception is D_Wr, which follows Mem_Ready while a store waits.
module control_sequencer #(
  parameter int PC_W     = 7,
  parameter int DA_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [15:0]     Imem_Data,
  input  logic            Mem_Ready,
  input  logic            Ra_Zero,
  input  logic            Go,
  output logic [PC_W-1:0] Imem_Addr,
  output logic [DA_W-1:0] D_Addr,
  output logic            D_Wr,
  output logic            RF_s,
  output logic            RF_W_en,
  output logic [3:0]      RF_W_Addr,
  output logic [3:0]      RF_Ra_Addr,
  output logic [3:0]      RF_Rb_Addr,
  output logic [2:0]      ALU_s0,
  output logic [PC_W-1:0] PC_Out,
  output logic [15:0]     IR_Out,
  output logic [3:0]      OutState,
  output logic [3:0]      NextState,
  output logic            Halted,
  output logic            Illegal
);

  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

  typedef enum logic [3:0] {
    S_INIT    = 4'd0,
    S_FETCH_A = 4'd1,
    S_FETCH_D = 4'd2,
    S_DECODE  = 4'd3,
    S_NOOP    = 4'd4,
    S_LOAD_A  = 4'd5,
    S_LOAD_B  = 4'd6,
    S_STORE   = 4'd7,
    S_ALU     = 4'd8,
    S_JUMP    = 4'd9,
    S_HALT    = 4'd10
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            illegal_q, illegal_d;

  logic [3:0]      opcode;
  logic [DA_W-1:0] d_addr_field;
  logic [PC_W-1:0] jz_off;

  assign opcode       = ir_q[15:12];
  assign d_addr_field = ir_q[11:12-DA_W];

  // JZ offset: IR[7:0] sign-extended to the PC width. A PC narrower than
  // eight bits only needs the low bits, since the add wraps modulo 2^PC_W.
  if (PC_W > 8) begin : g_jz_sext
    assign jz_off = {{(PC_W-8){ir_q[7]}}, ir_q[7:0]};
  end else begin : g_jz_trunc
    assign jz_off = ir_q[PC_W-1:0];
  end

  // Next state and the next values of PC, IR and the sticky illegal flag.
  // NOTE: every signal assigned here gets a default first, so a path that
  // does not mention it holds its value instead of inferring a latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_INIT: begin
        pc_d    = RESET_PC_V;
        state_d = S_FETCH_A;
      end
      S_FETCH_A: state_d = S_FETCH_D;
      S_FETCH_D: begin
        ir_d    = Imem_Data;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          4'b0000:          state_d = S_NOOP;
          4'b0001:          state_d = S_STORE;
          4'b0010:          state_d = S_LOAD_A;
          4'b0011, 4'b0100: state_d = S_ALU;
          4'b0101:          state_d = S_HALT;
          4'b0110, 4'b0111: state_d = S_JUMP;
          default: begin
            state_d   = S_NOOP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_NOOP:   state_d = S_FETCH_A;
      S_LOAD_A: if (Mem_Ready) state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_FETCH_A;
      S_STORE:  if (Mem_Ready) state_d = S_FETCH_A;
      S_ALU:    state_d = S_FETCH_A;
      S_JUMP: begin
        // Opcode bit 12 separates JMP (0111) from JZ (0110).
        if (ir_q[12]) begin
          pc_d = ir_q[PC_W-1:0];
        end else if (Ra_Zero) begin
          pc_d = pc_q + jz_off;
        end
        state_d = S_FETCH_A;
      end
      S_HALT:  if (Go) state_d = S_FETCH_A;
      default: state_d = S_INIT;
    endcase
  end

  // State, PC, IR and flag registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_INIT;
      pc_q      <= RESET_PC_V;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Datapath controls decoded from the current state and IR fields.
  always_comb begin
    D_Addr     = '0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_en    = 1'b0;
    RF_W_Addr  = '0;
    RF_Ra_Addr = '0;
    RF_Rb_Addr = '0;
    ALU_s0     = '0;
    case (state_q)
      S_STORE: begin
        D_Addr     = d_addr_field;
        RF_Ra_Addr = ir_q[3:0];
        // A store interrupted by reset must not complete its write.
        D_Wr       = Mem_Ready & ~Reset;
      end
      S_LOAD_A: begin
        D_Addr = d_addr_field;
        RF_s   = 1'b1;
      end
      S_LOAD_B: begin
        D_Addr    = d_addr_field;
        RF_s      = 1'b1;
        RF_W_Addr = ir_q[3:0];
        RF_W_en   = 1'b1;
      end
      S_ALU: begin
        RF_Ra_Addr = ir_q[11:8];
        RF_Rb_Addr = ir_q[7:4];
        RF_W_Addr  = ir_q[3:0];
        RF_W_en    = 1'b1;
        ALU_s0     = (opcode == 4'b0011) ? 3'b001 : 3'b010;
      end
      S_JUMP: begin
        if (!ir_q[12]) RF_Ra_Addr = ir_q[11:8];
      end
      default: ;
    endcase
  end

  assign Imem_Addr = pc_q;
  assign PC_Out    = pc_q;
  assign IR_Out    = ir_q;
  assign OutState  = state_q;
  assign NextState = state_d;
  assign Halted    = (state_q == S_HALT);
  assign Illegal   = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer. Two instances: default widths,
// and PC_W=4 for the PC wrap case. Both ROMs are modelled as synchronous
// memories. Outputs are sampled on the falling clock edge.
module tb_control_sequencer;

  localparam int INIT = 0, FA = 1, FD = 2, DEC = 3, NOOP = 4, LDA = 5,
                 LDB = 6, STORE = 7, ALU = 8, JUMP = 9, HALT = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main instance (PC_W=7) ----------------
  logic        reset, mem_ready, ra_zero, go;
  logic [15:0] imem_data;
  logic [6:0]  imem_addr, pc_out;
  logic [7:0]  d_addr;
  logic        d_wr, rf_s, rf_w_en, halted, illegal;
  logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, out_state, next_state;
  logic [2:0]  alu_s0;
  logic [15:0] ir_out;
  logic [15:0] rom [0:127];

  always @(posedge clk) imem_data <= rom[imem_addr];

  control_sequencer dut (
    .Clk(clk), .Reset(reset), .Imem_Data(imem_data), .Mem_Ready(mem_ready),
    .Ra_Zero(ra_zero), .Go(go), .Imem_Addr(imem_addr), .D_Addr(d_addr),
    .D_Wr(d_wr), .RF_s(rf_s), .RF_W_en(rf_w_en), .RF_W_Addr(rf_w_addr),
    .RF_Ra_Addr(rf_ra_addr), .RF_Rb_Addr(rf_rb_addr), .ALU_s0(alu_s0),
    .PC_Out(pc_out), .IR_Out(ir_out), .OutState(out_state),
    .NextState(next_state), .Halted(halted), .Illegal(illegal)
  );

  // ---------------- narrow instance (PC_W=4) ----------------
  logic        reset_4;
  logic [15:0] imem_data_4;
  logic [3:0]  imem_addr_4, pc_out_4;
  logic [7:0]  d_addr_4;
  logic        d_wr_4, rf_s_4, rf_w_en_4, halted_4, illegal_4;
  logic [3:0]  rf_w_addr_4, rf_ra_addr_4, rf_rb_addr_4, out_state_4, next_state_4;
  logic [2:0]  alu_s0_4;
  logic [15:0] ir_out_4;
  logic [15:0] rom_4 [0:15];

  always @(posedge clk) imem_data_4 <= rom_4[imem_addr_4];

  control_sequencer #(.PC_W(4)) dut_4 (
    .Clk(clk), .Reset(reset_4), .Imem_Data(imem_data_4), .Mem_Ready(1'b0),
    .Ra_Zero(1'b0), .Go(1'b0), .Imem_Addr(imem_addr_4), .D_Addr(d_addr_4),
    .D_Wr(d_wr_4), .RF_s(rf_s_4), .RF_W_en(rf_w_en_4), .RF_W_Addr(rf_w_addr_4),
    .RF_Ra_Addr(rf_ra_addr_4), .RF_Rb_Addr(rf_rb_addr_4), .ALU_s0(alu_s0_4),
    .PC_Out(pc_out_4), .IR_Out(ir_out_4), .OutState(out_state_4),
    .NextState(next_state_4), .Halted(halted_4), .Illegal(illegal_4)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // State, PC and instruction address of the main instance.
  task automatic expect_sp(input string tag, input int st, input int pc);
    check({tag, ".state"}, 32'(out_state), 32'(st));
    check({tag, ".pc"},    32'(pc_out),    32'(pc));
    check({tag, ".iaddr"}, 32'(imem_addr), 32'(pc));
  endtask

  task automatic expect_sp4(input string tag, input int st, input int pc);
    check({tag, ".state"}, 32'(out_state_4), 32'(st));
    check({tag, ".pc"},    32'(pc_out_4),    32'(pc));
    check({tag, ".iaddr"}, 32'(imem_addr_4), 32'(pc));
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 16'h5000;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cyc();
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b0; ra_zero = 1'b0; go = 1'b0; reset_4 = 1'b1;
    clear_rom();
    for (int i = 0; i < 16; i++) rom_4[i] = 16'h0000;
    cyc();
    cyc();

    // ---- reset state ----
    expect_sp("rst", INIT, 0);
    check("rst.ir",      32'(ir_out),  32'h0);
    check("rst.illegal", 32'(illegal), 32'h0);
    check("rst.halted",  32'(halted),  32'h0);
    check("rst.wen",     32'(rf_w_en), 32'h0);
    check("rst.dwr",     32'(d_wr),    32'h0);

    // ---- LOAD R5<-M[0x10]; ADD R3=R1+R2; HALT ----
    rom[0] = 16'h2105; rom[1] = 16'h3123; rom[2] = 16'h5000;
    mem_ready = 1'b1;
    reset = 1'b0;
    expect_sp("p1.init", INIT, 0); cyc();
    expect_sp("p1.fa0", FA, 0);    cyc();
    expect_sp("p1.fd0", FD, 0);    cyc();
    expect_sp("p1.dec0", DEC, 1);
    check("p1.ir0",    32'(ir_out),     32'h2105);
    check("p1.nxt0",   32'(next_state), 32'(LDA));
    cyc();
    expect_sp("p1.lda", LDA, 1);
    check("p1.lda.daddr", 32'(d_addr),  32'h10);
    check("p1.lda.rfs",   32'(rf_s),    32'h1);
    check("p1.lda.wen",   32'(rf_w_en), 32'h0);
    check("p1.lda.dwr",   32'(d_wr),    32'h0);
    cyc();
    expect_sp("p1.ldb", LDB, 1);
    check("p1.ldb.wen",   32'(rf_w_en),   32'h1);
    check("p1.ldb.waddr", 32'(rf_w_addr), 32'h5);
    check("p1.ldb.daddr", 32'(d_addr),    32'h10);
    check("p1.ldb.rfs",   32'(rf_s),      32'h1);
    check("p1.ldb.dwr",   32'(d_wr),      32'h0);
    cyc();
    expect_sp("p1.fa1", FA, 1);   cyc();
    expect_sp("p1.fd1", FD, 1);   cyc();
    expect_sp("p1.dec1", DEC, 2); cyc();
    expect_sp("p1.alu", ALU, 2);
    check("p1.alu.op",    32'(alu_s0),     32'h1);
    check("p1.alu.waddr", 32'(rf_w_addr),  32'h3);
    check("p1.alu.ra",    32'(rf_ra_addr), 32'h1);
    check("p1.alu.rb",    32'(rf_rb_addr), 32'h2);
    check("p1.alu.wen",   32'(rf_w_en),    32'h1);
    check("p1.alu.rfs",   32'(rf_s),       32'h0);
    check("p1.alu.dwr",   32'(d_wr),       32'h0);
    cyc();
    expect_sp("p1.fa2", FA, 2);   cyc();
    expect_sp("p1.fd2", FD, 2);   cyc();
    expect_sp("p1.dec2", DEC, 3); cyc();
    expect_sp("p1.halt", HALT, 3);
    check("p1.halted",    32'(halted),  32'h1);
    check("p1.halt.wen",  32'(rf_w_en), 32'h0);
    check("p1.halt.dwr",  32'(d_wr),    32'h0);
    check("p1.halt.alu",  32'(alu_s0),  32'h0);

    // ---- HALT holds with Go=0 for 10 cycles, resumes on a 1-cycle Go ----
    for (int i = 0; i < 10; i++) begin
      cyc();
      expect_sp($sformatf("hold%0d", i), HALT, 3);
    end
    check("hold.ir", 32'(ir_out), 32'h5000);
    go = 1'b1;
    cyc();
    go = 1'b0;
    expect_sp("resume", FA, 3);
    check("resume.halted", 32'(halted), 32'h0);
    check("resume.ir",     32'(ir_out), 32'h5000);

    // ---- STORE 0x1AB2 with a 4-cycle memory stall ----
    apply_reset();
    clear_rom();
    rom[0] = 16'h1AB2;
    mem_ready = 1'b0;
    reset = 1'b0;
    expect_sp("st.init", INIT, 0); cyc();
    expect_sp("st.fa", FA, 0);     cyc();
    expect_sp("st.fd", FD, 0);     cyc();
    expect_sp("st.dec", DEC, 1);   cyc();
    for (int i = 0; i < 4; i++) begin
      expect_sp($sformatf("st.wait%0d", i), STORE, 1);
      check($sformatf("st.wait%0d.dwr", i),   32'(d_wr),       32'h0);
      check($sformatf("st.wait%0d.daddr", i), 32'(d_addr),     32'hAB);
      check($sformatf("st.wait%0d.ra", i),    32'(rf_ra_addr), 32'h2);
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    check("st.go.state", 32'(out_state),  32'(STORE));
    check("st.go.dwr",   32'(d_wr),       32'h1);
    check("st.go.wen",   32'(rf_w_en),    32'h0);
    check("st.go.nxt",   32'(next_state), 32'(FA));
    cyc();
    expect_sp("st.done", FA, 1);
    check("st.done.dwr", 32'(d_wr), 32'h0);
    mem_ready = 1'b0;

    // ---- JZ 0x61FE at PC 5, Ra_Zero=1 then 0 ----
    apply_reset();
    clear_rom();
    rom[0] = 16'h7005; rom[4] = 16'h7005; rom[5] = 16'h61FE;
    ra_zero = 1'b1;
    reset = 1'b0;
    expect_sp("jz.init", INIT, 0); cyc();
    expect_sp("jz.fa0", FA, 0);    cyc();
    expect_sp("jz.fd0", FD, 0);    cyc();
    expect_sp("jz.dec0", DEC, 1);  cyc();
    expect_sp("jz.jmp0", JUMP, 1); cyc();
    expect_sp("jz.fa1", FA, 5);    cyc();
    expect_sp("jz.fd1", FD, 5);    cyc();
    expect_sp("jz.dec1", DEC, 6);  cyc();
    expect_sp("jz.jz1", JUMP, 6);
    check("jz.jz1.ra", 32'(rf_ra_addr), 32'h1);
    check("jz.jz1.ir", 32'(ir_out),     32'h61FE);
    cyc();
    expect_sp("jz.taken", FA, 4);
    ra_zero = 1'b0;
    cyc();
    expect_sp("jz.fd2", FD, 4);    cyc();
    expect_sp("jz.dec2", DEC, 5);  cyc();
    expect_sp("jz.jmp2", JUMP, 5);
    check("jz.jmp2.ra", 32'(rf_ra_addr), 32'h0);
    cyc();
    expect_sp("jz.fa3", FA, 5);    cyc();
    expect_sp("jz.fd3", FD, 5);    cyc();
    expect_sp("jz.dec3", DEC, 6);  cyc();
    expect_sp("jz.jz3", JUMP, 6);
    check("jz.jz3.ra", 32'(rf_ra_addr), 32'h1);
    cyc();
    expect_sp("jz.nottaken", FA, 6);
    ra_zero = 1'b0;

    // ---- Illegal opcode 0xF, then reset during a STORE stall ----
    apply_reset();
    clear_rom();
    rom[0] = 16'hF000; rom[1] = 16'h1AB2;
    mem_ready = 1'b0;
    reset = 1'b0;
    expect_sp("il.init", INIT, 0); cyc();
    expect_sp("il.fa0", FA, 0);    cyc();
    expect_sp("il.fd0", FD, 0);    cyc();
    expect_sp("il.dec0", DEC, 1);
    check("il.dec0.ill", 32'(illegal),    32'h0);
    check("il.dec0.nxt", 32'(next_state), 32'(NOOP));
    cyc();
    expect_sp("il.noop", NOOP, 1);
    check("il.noop.ill", 32'(illegal), 32'h1);
    cyc();
    expect_sp("il.fa1", FA, 1);    cyc();
    expect_sp("il.fd1", FD, 1);    cyc();
    expect_sp("il.dec1", DEC, 2);  cyc();
    expect_sp("il.st0", STORE, 2);
    check("il.st0.ill", 32'(illegal), 32'h1);
    cyc();
    expect_sp("il.st1", STORE, 2);
    check("il.st1.ill", 32'(illegal), 32'h1);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("il.rst.dwr", 32'(d_wr), 32'h0);
    cyc();
    expect_sp("il.rst", INIT, 0);
    check("il.rst.ir",     32'(ir_out),  32'h0);
    check("il.rst.ill",    32'(illegal), 32'h0);
    check("il.rst.halted", 32'(halted),  32'h0);
    check("il.rst.dwr2",   32'(d_wr),    32'h0);
    mem_ready = 1'b0;

    // ---- PC_W=4: JMP to 0xF, the fetch at 15 wraps the PC to 0 ----
    rom_4[0] = 16'h700F;
    reset_4 = 1'b0;
    expect_sp4("w.init", INIT, 0); cyc();
    expect_sp4("w.fa0", FA, 0);    cyc();
    expect_sp4("w.fd0", FD, 0);    cyc();
    expect_sp4("w.dec0", DEC, 1);  cyc();
    expect_sp4("w.jmp", JUMP, 1);  cyc();
    expect_sp4("w.fa1", FA, 15);   cyc();
    expect_sp4("w.fd1", FD, 15);   cyc();
    expect_sp4("w.wrap", DEC, 0);
    check("w.wrap.ir",  32'(ir_out_4),  32'h0);
    check("w.wrap.ill", 32'(illegal_4), 32'h0);
    cyc();
    expect_sp4("w.noop", NOOP, 0); cyc();
    expect_sp4("w.fa2", FA, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
